// File: rtl/seven_seg_scan_reader_pkg.sv
// Shared constants for the 7-segment scan reader: glyph table (bit0=a .. bit6=g,
// active-high), special digit codes and the stability FSM states.
package seven_seg_scan_reader_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BAD_CODE   = 4'hE;

  typedef enum logic [1:0] {
    ST_WAIT_SEL,
    ST_SETTLING,
    ST_HELD
  } state_e;

endpackage

// File: rtl/seven_seg_scan_reader_seg7_to_bcd.sv
// Combinational inverse of the BCD-to-7seg table: pattern -> code plus legal flag.
// Blank is legal (code F); every unlisted pattern is illegal (code E).
module seg7_to_bcd
  import seven_seg_scan_reader_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] code_o,
  output logic       legal_o
);

  always_comb begin
    code_o  = BAD_CODE;
    legal_o = 1'b1;
    case (pattern_i)
      GLYPH_0:     code_o = 4'd0;
      GLYPH_1:     code_o = 4'd1;
      GLYPH_2:     code_o = 4'd2;
      GLYPH_3:     code_o = 4'd3;
      GLYPH_4:     code_o = 4'd4;
      GLYPH_5:     code_o = 4'd5;
      GLYPH_6:     code_o = 4'd6;
      GLYPH_7:     code_o = 4'd7;
      GLYPH_8:     code_o = 4'd8;
      GLYPH_9:     code_o = 4'd9;
      GLYPH_BLANK: code_o = BLANK_CODE;
      default:     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Receive-side reader for the multiplexed 4-digit 7-segment bus: filters each
// scanned digit for stability, decodes it, and assembles MM:SS frames.
module seven_seg_scan_reader
  import seven_seg_scan_reader_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1,
  parameter int unsigned FRAME_TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  dig_i,
  output logic [15:0] digits_o,
  output logic [12:0] seconds_o,
  output logic        frame_valid_o,
  output logic        bad_glyph_o,
  output logic        multi_sel_o,
  output logic        stale_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [6:0]  SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]  DIG_IDLE = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [6:0]    seg_q, pat_n, pat_q, pat_d;
  logic [3:0]    dig_q, en_n;
  logic          sel_valid, multi_now, same, load, capture, frame_done;
  logic [1:0]    idx_now, idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [3:0]    code;
  logic          legal;
  logic [15:0]   shadow_q, shadow_d, digits_q;
  logic [3:0]    seen_q, seen_d;
  logic [12:0]   seconds_q, mins, total;
  logic          all_bcd, frame_q, bad_q, multi_q, multi_prev_q, stale_q;
  logic [TW-1:0] tcnt_q, tcnt_d;

  assign pat_n     = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign en_n      = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
  assign sel_valid = $onehot(en_n);
  assign multi_now = $countones(en_n) > 1;
  assign same      = (idx_now == idx_q) && (pat_n == pat_q);

  always_comb begin
    idx_now = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (en_n[i]) idx_now = i[1:0];
    end
  end

  seg7_to_bcd u_dec (
    .pattern_i (pat_n),
    .code_o    (code),
    .legal_o   (legal)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_WAIT_SEL: load = sel_valid;
      ST_SETTLING: begin
        if (!sel_valid) state_d = ST_WAIT_SEL;
        else if (!same) load = 1'b1;
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
            capture = 1'b1;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!sel_valid) state_d = ST_WAIT_SEL;
        else if (!same) load = 1'b1;
      end
      default: state_d = ST_WAIT_SEL;
    endcase
    // A fresh selection counts as the first stable sample; with SETTLE_CYCLES==1 it is already enough.
    if (load) begin
      idx_d = idx_now;
      pat_d = pat_n;
      cnt_d = CW'(1);
      if (SETTLE_CYCLES == 1) begin
        capture = 1'b1;
        state_d = ST_HELD;
      end else begin
        state_d = ST_SETTLING;
      end
    end
  end

  always_comb begin
    shadow_d   = shadow_q;
    seen_d     = seen_q;
    frame_done = 1'b0;
    if (capture) begin
      shadow_d[{idx_now, 2'b00} +: 4] = code;
      seen_d[idx_now] = 1'b1;
      frame_done      = (seen_d == 4'hF);
      if (frame_done) seen_d = '0;
    end
    all_bcd = (shadow_d[15:12] < 4'd10) && (shadow_d[11:8] < 4'd10) &&
              (shadow_d[7:4] < 4'd10) && (shadow_d[3:0] < 4'd10);
    mins  = 13'(shadow_d[15:12]) * 13'd10 + 13'(shadow_d[11:8]);
    total = (mins << 6) - (mins << 2) + 13'(shadow_d[7:4]) * 13'd10 + 13'(shadow_d[3:0]);
    // Frame completion takes priority over timeout expiry.
    if (frame_done) tcnt_d = '0;
    else if (tcnt_q != TW'(FRAME_TIMEOUT)) tcnt_d = tcnt_q + 1'b1;
    else tcnt_d = tcnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_IDLE;
      dig_q        <= DIG_IDLE;
      state_q      <= ST_WAIT_SEL;
      idx_q        <= '0;
      pat_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '1;
      seen_q       <= '0;
      digits_q     <= '1;
      seconds_q    <= '0;
      frame_q      <= 1'b0;
      bad_q        <= 1'b0;
      multi_q      <= 1'b0;
      multi_prev_q <= 1'b0;
      tcnt_q       <= '0;
      stale_q      <= 1'b0;
    end else begin
      seg_q        <= seg_i;
      dig_q        <= dig_i;
      state_q      <= state_d;
      idx_q        <= idx_d;
      pat_q        <= pat_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      seen_q       <= seen_d;
      frame_q      <= frame_done;
      bad_q        <= capture && !legal;
      multi_q      <= multi_now && !multi_prev_q;
      multi_prev_q <= multi_now;
      tcnt_q       <= tcnt_d;
      stale_q      <= (tcnt_d == TW'(FRAME_TIMEOUT));
      if (frame_done) begin
        digits_q <= shadow_d;
        if (all_bcd) seconds_q <= total;
      end
    end
  end

  assign digits_o      = digits_q;
  assign seconds_o     = seconds_q;
  assign frame_valid_o = frame_q;
  assign bad_glyph_o   = bad_q;
  assign multi_sel_o   = multi_q;
  assign stale_o       = stale_q;

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Self-checking bench for seven_seg_scan_reader: table frames, random frames
// against a seconds model, and hand sequences for settling, multi-select, reset, stale.
module tb_seven_seg_scan_reader;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_i;
  logic [3:0]  dig_i;
  logic [15:0] digits_o;
  logic [12:0] seconds_o;
  logic        frame_valid_o, bad_glyph_o, multi_sel_o, stale_o;

  always #5 clk = ~clk;

  seven_seg_scan_reader #(
    .SETTLE_CYCLES  (SETTLE),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1),
    .FRAME_TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_i         (seg_i),
    .dig_i         (dig_i),
    .digits_o      (digits_o),
    .seconds_o     (seconds_o),
    .frame_valid_o (frame_valid_o),
    .bad_glyph_o   (bad_glyph_o),
    .multi_sel_o   (multi_sel_o),
    .stale_o       (stale_o)
  );

  int          checks = 0, errors = 0;
  int          frames = 0, bads = 0, multis = 0;
  logic [15:0] last_dig = '0;
  logic [12:0] last_sec = '0;
  int unsigned model_sec = 0;

  always @(negedge clk) begin
    if (frame_valid_o) begin
      frames++;
      last_dig = digits_o;
      last_sec = seconds_o;
    end
    if (bad_glyph_o) bads++;
    if (multi_sel_o) multis++;
  end

  typedef struct {
    logic [15:0] codes;
    int          hold;
    logic [15:0] exp_dig;
    int unsigned exp_sec;
    int          exp_bad;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  4'hF: return 7'h00;
      default: return 7'h55;
    endcase
  endfunction

  function automatic bit all_bcd(input logic [15:0] d);
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int unsigned ref_seconds(input logic [15:0] d);
    int unsigned dm, um, ds, us;
    dm = d[15:12]; um = d[11:8]; ds = d[7:4]; us = d[3:0];
    return (dm * 10 + um) * 60 + ds * 10 + us;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] pat, input int n);
    dig_i = ~en;
    seg_i = ~pat;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive(4'h0, 7'h00, n);
  endtask

  task automatic scan(input logic [15:0] codes, input int hold);
    for (int i = 0; i < 4; i++) drive(4'b0001 << i, glyph(codes[i*4 +: 4]), hold);
    idle(6);
  endtask

  task automatic run_frame(input string name, input logic [15:0] codes, input int hold,
                           input logic [15:0] exp_dig, input int unsigned exp_sec,
                           input int exp_bad);
    int f0, b0;
    f0 = frames;
    b0 = bads;
    scan(codes, hold);
    check({name, " frame pulses"}, frames - f0, 1);
    check({name, " bad pulses"}, bads - b0, exp_bad);
    check({name, " digits"}, last_dig, exp_dig);
    check({name, " seconds"}, last_sec, exp_sec);
  endtask

  initial begin
    int f0, m0, b0;
    logic [15:0] codes;
    int unsigned exp_sec;

    tbl[0] = '{16'h4321, 8, 16'h4321, 2601, 0};
    tbl[1] = '{16'h5959, 8, 16'h5959, 3599, 0};
    tbl[2] = '{16'h0000, 8, 16'h0000, 0,    0};
    tbl[3] = '{16'h9959, 8, 16'h9959, 5999, 0};
    tbl[4] = '{16'hF230, 8, 16'hF230, 5999, 0};
    tbl[5] = '{16'h12E4, 8, 16'h12E4, 5999, 1};
    tbl[6] = '{16'h1005, 8, 16'h1005, 605,  0};
    tbl[7] = '{16'h0812, SETTLE, 16'h0812, 492, 0};

    rst_n = 1'b0;
    seg_i = '1;
    dig_i = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset digits", digits_o, 16'hFFFF);
    check("reset seconds", seconds_o, 0);
    check("reset frame_valid", frame_valid_o, 0);
    check("reset bad_glyph", bad_glyph_o, 0);
    check("reset multi_sel", multi_sel_o, 0);
    check("reset stale", stale_o, 0);
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].codes, tbl[i].hold,
                tbl[i].exp_dig, tbl[i].exp_sec, tbl[i].exp_bad);
    model_sec = 492;

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 4; i++) codes[i*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) codes[$urandom_range(0, 3)*4 +: 4] = 4'hF;
      exp_sec = all_bcd(codes) ? ref_seconds(codes) : model_sec;
      model_sec = exp_sec;
      run_frame($sformatf("rnd%0d", n), codes, $urandom_range(SETTLE, SETTLE + 6),
                codes, exp_sec, 0);
    end

    // One cycle short of settling on digit1: no capture, so no frame until it is rescanned.
    f0 = frames;
    drive(4'b0001, glyph(4'd7), SETTLE - 1);
    drive(4'b0010, glyph(4'd4), 8);
    drive(4'b0100, glyph(4'd6), 8);
    drive(4'b1000, glyph(4'd5), 8);
    idle(6);
    check("short hold no frame", frames - f0, 0);
    drive(4'b0001, glyph(4'd7), 8);
    idle(6);
    check("short hold rescan frame", frames - f0, 1);
    check("short hold digits", last_dig, 16'h5647);
    check("short hold seconds", last_sec, 3407);

    f0 = frames;
    m0 = multis;
    b0 = bads;
    drive(4'b0011, glyph(4'd8), 10);
    idle(4);
    check("multi pulses", multis - m0, 1);
    check("multi no frame", frames - f0, 0);
    check("multi no bad", bads - b0, 0);

    drive(4'b0001, glyph(4'd9), 8);
    drive(4'b0010, glyph(4'd9), 4);
    rst_n = 1'b0;
    #2;
    check("midreset digits", digits_o, 16'hFFFF);
    check("midreset seconds", seconds_o, 0);
    check("midreset frame_valid", frame_valid_o, 0);
    check("midreset stale", stale_o, 0);
    idle(3);
    rst_n = 1'b1;
    f0 = frames;
    drive(4'b0100, glyph(4'd2), 8);
    drive(4'b1000, glyph(4'd1), 8);
    idle(6);
    check("after reset partial discarded", frames - f0, 0);
    drive(4'b0001, glyph(4'd5), 8);
    drive(4'b0010, glyph(4'd3), 8);
    idle(6);
    check("after reset frame", frames - f0, 1);
    check("after reset digits", last_dig, 16'h1235);
    check("after reset seconds", last_sec, 755);

    check("stale after frame", stale_o, 0);
    idle(TIMEOUT - 30);
    check("stale before timeout", stale_o, 0);
    idle(40);
    check("stale after timeout", stale_o, 1);
    run_frame("post stale", 16'h0001, 8, 16'h0001, 1, 0);
    check("stale cleared by frame", stale_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
